spike_encoder: RTL and testbench
================================

# spike_encoder

Temporal input encoder for a TNN column. It converts a wave of binary spike-time values into per-channel spike pulses, each `PW` unit-clock cycles wide, timed relative to the gamma-wave start pulse `grst`. It sits between the host/data source and the column's `input_spikes` bus, and is the transmitter for the column's pulse-encoded input protocol. A one-entry staging buffer with a valid/ready handshake lets the host load the next wave while the current one plays out.

## Interface
- `P`, 64: number of spike channels; matches the column synapse count.
- `TRES`, 3: bit resolution of each spike time.
- `PW`, 8: output pulse width in unit clock cycles; equals `(1<<TRES)`.
- `clk`  in  1: unit clock for temporal encoding.
- `rstb`  in  1: asynchronous active-low reset.
- `grst`  in  1: 1-cycle gamma-start pulse, synchronous to `clk`.
- `in_valid`  in  1: host offers a wave.
- `in_ready`  out  1: staging buffer empty, so a wave can be accepted.
- `in_times`  in  `[P-1:0][TRES-1:0]`: spike time `v` per channel.
- `in_mask`  in  `[P-1:0]`: 1 means the channel spikes; 0 means null (no spike this wave).
- `spike_out`  out  `[P-1:0]`: pulse-encoded spikes driving the column `input_spikes`.
- `underrun`  out  1: 1-cycle flag set when `grst` finds the staging buffer empty.

## Operation
- **Staging register.** Holds `stg_times`, `stg_mask` and `stg_full`.
  - `in_ready = !stg_full`.
  - Accept occurs on a `clk` edge with `in_valid & in_ready`: capture `in_times`/`in_mask` and set `stg_full`.
- **Active register.** Holds `act_times` and `act_mask` for the wave currently playing.
- **On a `clk` edge with `grst`=1:**
  - If `stg_full`: active <= staging, and `stg_full` <= 0.
  - If not `stg_full`: `act_mask` <= 0 and `underrun` <= 1 for one cycle. The wave is silent.
  - Time counter `t` <= 0.
  - A handshake accepted on the same edge goes into staging for the next wave, never the current one. It is only possible when staging was empty.
- **Time counter `t`.** Width `TRES+1` bits plus enough for `PW`, so it holds 0..`(1<<TRES)+PW`.
  - Increments each cycle.
  - Saturates at `(1<<TRES)+PW` and holds until the next `grst`.
- **Channel output.** Let cycle `k` be the k-th cycle after the `grst` edge (cycle 0 immediately follows it).
  - `spike_out[i]` is high in cycle `k` iff `act_mask[i]` and `v+1 <= k <= v+PW`, where `v = act_times[i]`.
  - Rising edges therefore occur at least one cycle after gamma start, as the column's STDP timing requires.
- **Registered output.** `spike_out` is driven directly from flops, with no combinational path from inputs.
- **Early `grst`** (wave shorter than `(1<<TRES)+PW` cycles): all pulses in flight are cut. `spike_out` is 0 in cycle 0 of the new wave.
- **Before the first `grst` after reset:** `t` is saturated and `act_mask` is 0, so there is no output.

## Timing
- **Reset values (`rstb`=0, asynchronous):**
  - `spike_out`=0, `underrun`=0, `in_ready`=1.
  - `stg_full`=0, `act_mask`=0.
  - `t`=saturated.
- Reset mid-wave forces `spike_out` low immediately, without waiting for a clock edge.
- **Handshake:** `in_ready` falls the cycle after an accept. It rises the cycle after the `grst` edge that drains staging.
- **Latency:** a wave accepted before `grst` edge N plays in the wave started by N. The first possible spike edge is cycle 1 after N. The last pulse (`v`=7) is high in cycles 8..15.
- **Minimum gamma period** without truncation: `(1<<TRES)+PW` = 16 cycles, with `grst` every 16th cycle.
- `underrun` is high for exactly the cycle after an empty-staging `grst` edge.
- **Back-to-back waves:** a pulse ending in cycle 15 and a `grst` edge after cycle 15 give a clean 0 in cycle 0 of the next wave.

## Test plan
1. **Reset:** assert `rstb`=0 mid-stream → `spike_out`=0 asynchronously, `in_ready`=1, `underrun`=0; no spikes after release until a loaded `grst`.
2. **Basic wave:** load ch0 `v`=0, ch1 `v`=7, ch2 mask=0, ch3 `v`=3; then `grst` → ch0 high cycles 1–8, ch1 high 8–15, ch2 never high, ch3 high 4–11.
3. **Underrun:** issue `grst` with staging empty → `underrun`=1 in cycle 0 only; all `spike_out`=0 for 16 cycles; `in_ready` stays 1.
4. **Backpressure:** offer two waves A then B before `grst` → A accepted and `in_ready`=0; B stalls until the cycle after `grst`, then is accepted. A plays in wave 1 and B plays in wave 2.
5. **Simultaneous accept and `grst`:** staging empty, `in_valid`=1 on the `grst` edge → `underrun`=1, current wave silent, accepted data plays in the following wave.
6. **Early `grst`:** ch0 `v`=2, then a second `grst` at cycle 5 of the wave → ch0 high cycles 3–5 and 0 in cycle 0 of the new wave; the new wave's timing restarts from its own `grst`.

Source files
------------

// File: rtl/spike_encoder_if.sv
// Host-side wave delivery bundle for spike_encoder: one wave of spike times
// plus a per-channel spike mask, moved with a valid/ready handshake.
interface spike_encoder_if #(
  parameter int P    = 64,
  parameter int TRES = 3
);
  // A transfer happens on a clock edge where in_valid and in_ready are both 1.
  // The host holds in_times/in_mask stable while in_valid is high and not yet
  // accepted; in_ready never depends on in_valid.
  logic                     in_valid;
  logic                     in_ready;
  logic [P-1:0][TRES-1:0]   in_times;
  logic [P-1:0]             in_mask;

  modport master (
    output in_valid,
    output in_times,
    output in_mask,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_times,
    input  in_mask,
    output in_ready
  );
endinterface

// File: rtl/spike_encoder.sv
// Temporal input encoder: plays one staged wave per gamma cycle as PW-wide
// per-channel pulses, each starting v+1 cycles after the grst edge.
module spike_encoder #(
  parameter int P    = 64,
  parameter int TRES = 3,
  parameter int PW   = 8
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                grst,
  spike_encoder_if.slave      in_if,
  output logic [P-1:0]        spike_out,
  output logic                underrun
);

  localparam int              TMAX  = (1 << TRES) + PW;
  localparam int              TW    = $clog2(TMAX + 1);
  localparam logic [TW-1:0]   T_SAT = TW'(TMAX);
  localparam logic [TW-1:0]   PW_T  = TW'(PW);

  logic [P-1:0][TRES-1:0] stg_times_q, stg_times_d;
  logic [P-1:0]           stg_mask_q,  stg_mask_d;
  logic                   stg_full_q,  stg_full_d;
  logic [P-1:0][TRES-1:0] act_times_q, act_times_d;
  logic [P-1:0]           act_mask_q,  act_mask_d;
  logic [TW-1:0]          t_q,         t_d;
  logic [P-1:0]           spike_q,     spike_d;
  logic                   underrun_q,  underrun_d;
  logic                   accept;

  assign in_if.in_ready = ~stg_full_q;
  assign spike_out      = spike_q;
  assign underrun       = underrun_q;

  always_comb begin
    stg_times_d = stg_times_q;
    stg_mask_d  = stg_mask_q;
    stg_full_d  = stg_full_q;
    act_times_d = act_times_q;
    act_mask_d  = act_mask_q;
    t_d         = t_q;
    underrun_d  = 1'b0;
    accept      = in_if.in_valid & ~stg_full_q;

    if (grst) begin
      t_d = '0;
      if (stg_full_q) begin
        act_times_d = stg_times_q;
        act_mask_d  = stg_mask_q;
        stg_full_d  = 1'b0;
      end else begin
        act_mask_d  = '0;
        underrun_d  = 1'b1;
      end
    end else if (t_q != T_SAT) begin
      t_d = t_q + 1'b1;
    end

    // Only possible with staging empty, so it always targets the next wave.
    if (accept) begin
      stg_times_d = in_if.in_times;
      stg_mask_d  = in_if.in_mask;
      stg_full_d  = 1'b1;
    end
  end

  // Output is registered: during cycle k-1 the counter holds k-1, so the
  // window v+1..v+PW at the output becomes v..v+PW-1 on t_q here.
  always_comb begin
    spike_d = '0;
    for (int i = 0; i < P; i++) begin
      spike_d[i] = ~grst & act_mask_q[i]
                 & (t_q >= TW'(act_times_q[i]))
                 & ((t_q - TW'(act_times_q[i])) < PW_T);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      stg_times_q <= '0;
      stg_mask_q  <= '0;
      stg_full_q  <= 1'b0;
      act_times_q <= '0;
      act_mask_q  <= '0;
      t_q         <= T_SAT;
      spike_q     <= '0;
      underrun_q  <= 1'b0;
    end else begin
      stg_times_q <= stg_times_d;
      stg_mask_q  <= stg_mask_d;
      stg_full_q  <= stg_full_d;
      act_times_q <= act_times_d;
      act_mask_q  <= act_mask_d;
      t_q         <= t_d;
      spike_q     <= spike_d;
      underrun_q  <= underrun_d;
    end
  end

endmodule

// File: tb/tb_spike_encoder.sv
// Bench for spike_encoder: directed waves plus random traffic against a
// cycle-index model of the pulse rule.
module tb_spike_encoder;
  localparam int P    = 64;
  localparam int TRES = 3;
  localparam int PW   = 8;
  localparam int K_IDLE = 1000;

  // clock / reset
  logic clk = 1'b0;
  logic rstb;
  logic grst;
  always #5 clk = ~clk;

  spike_encoder_if #(.P(P), .TRES(TRES)) bus ();
  logic [P-1:0] spike_out;
  logic         underrun;

  spike_encoder #(.P(P), .TRES(TRES), .PW(PW)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .grst      (grst),
    .in_if     (bus),
    .spike_out (spike_out),
    .underrun  (underrun)
  );

  typedef struct packed {
    logic [P-1:0][TRES-1:0] tm;
    logic [P-1:0]           mk;
  } wave_t;

  // reference model: waiting waves, wave playing, cycle index since grst
  wave_t  stg_q[$];
  wave_t  act;
  int     k;
  logic   exp_und;
  logic   last_acc;
  int     n_checks = 0;
  int     n_fail   = 0;

  task automatic check_eq(input string tag, input logic [P-1:0] got,
                          input logic [P-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [P-1:0] model_spikes();
    logic [P-1:0] r;
    r = '0;
    for (int i = 0; i < P; i++) begin
      int v;
      v = int'(act.tm[i]);
      r[i] = act.mk[i] && (k >= v + 1) && (k <= v + PW);
    end
    return r;
  endfunction

  task automatic model_reset();
    stg_q.delete();
    act     = '0;
    k       = K_IDLE;
    exp_und = 1'b0;
  endtask

  // driver: one clock cycle with the given inputs, then compare outputs
  task automatic step(input logic g, input logic v, input wave_t w);
    grst         = g;
    bus.in_valid = v;
    bus.in_times = w.tm;
    bus.in_mask  = w.mk;
    @(posedge clk);
    last_acc = v && (stg_q.size() == 0);
    exp_und  = 1'b0;
    if (g) begin
      if (stg_q.size() > 0) act = stg_q.pop_front();
      else begin
        act.mk  = '0;
        exp_und = 1'b1;
      end
      k = 0;
    end else if (k < K_IDLE) begin
      k++;
    end
    if (last_acc) stg_q.push_back(w);
    #1;
    check_eq("spk", spike_out, model_spikes());
    check_eq("und", P'(underrun), P'(exp_und));
    check_eq("rdy", P'(bus.in_ready), P'(stg_q.size() == 0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
  endtask

  function automatic wave_t rand_wave();
    wave_t w;
    for (int i = 0; i < P; i++) begin
      w.tm[i] = TRES'($urandom_range(0, (1 << TRES) - 1));
      w.mk[i] = 1'($urandom_range(0, 1));
    end
    return w;
  endfunction

  wave_t wa, wb, wc;
  logic [3:0] exp4;
  logic       pend;
  wave_t      hw;

  initial begin
    rstb = 1'b0;
    grst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_times = '0;
    bus.in_mask  = '0;
    model_reset();
    #12;
    check_eq("rst_spk", spike_out, '0);
    check_eq("rst_rdy", P'(bus.in_ready), P'(1));
    check_eq("rst_und", P'(underrun), '0);
    @(negedge clk);
    rstb = 1'b1;
    idle(4);

    // basic wave: ch0 v=0, ch1 v=7, ch2 masked, ch3 v=3
    wa = '0;
    wa.tm[0] = 3'd0; wa.mk[0] = 1'b1;
    wa.tm[1] = 3'd7; wa.mk[1] = 1'b1;
    wa.tm[2] = 3'd5; wa.mk[2] = 1'b0;
    wa.tm[3] = 3'd3; wa.mk[3] = 1'b1;
    step(1'b0, 1'b1, wa);
    step(1'b1, 1'b0, '0);
    check_eq("dir0", P'(spike_out[3:0]), '0);
    for (int kk = 1; kk <= 16; kk++) begin
      step(1'b0, 1'b0, '0);
      exp4[0] = (kk >= 1) && (kk <= 8);
      exp4[1] = (kk >= 8) && (kk <= 15);
      exp4[2] = 1'b0;
      exp4[3] = (kk >= 4) && (kk <= 11);
      check_eq("dir", P'(spike_out[3:0]), P'(exp4));
    end

    // underrun: grst with staging empty
    step(1'b1, 1'b0, '0);
    check_eq("und_dir", P'(underrun), P'(1));
    idle(16);

    // backpressure: A accepted, B stalls until after grst
    wa = rand_wave();
    wb = rand_wave();
    step(1'b0, 1'b1, wa);
    step(1'b0, 1'b1, wb);
    check_eq("bp_rdy", P'(bus.in_ready), '0);
    step(1'b1, 1'b1, wb);
    step(1'b0, 1'b1, wb);
    idle(15);
    step(1'b1, 1'b0, '0);
    idle(17);

    // simultaneous accept and grst on empty staging
    wc = rand_wave();
    step(1'b1, 1'b1, wc);
    check_eq("sim_und", P'(underrun), P'(1));
    idle(16);
    step(1'b1, 1'b0, '0);
    idle(17);

    // early grst: ch0 v=2 cut at cycle 5, same wave replays afterwards
    wa = '0;
    wa.tm[0] = 3'd2; wa.mk[0] = 1'b1;
    step(1'b0, 1'b1, wa);
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b1, wa);
    idle(4);
    check_eq("early5", P'(spike_out[0]), P'(1));
    step(1'b1, 1'b0, '0);
    check_eq("early0", P'(spike_out[0]), '0);
    idle(17);

    // asynchronous reset with pulses in flight
    wa = '1;
    step(1'b0, 1'b1, wa);
    step(1'b1, 1'b0, '0);
    idle(8);
    #3;
    rstb = 1'b0;
    #1;
    model_reset();
    check_eq("arst_spk", spike_out, '0);
    check_eq("arst_rdy", P'(bus.in_ready), P'(1));
    check_eq("arst_und", P'(underrun), '0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rstb = 1'b1;
    idle(20);

    // random traffic, host keeps an offer stable until it is taken
    pend = 1'b0;
    hw   = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!pend && $urandom_range(0, 1) == 1) begin
        pend = 1'b1;
        hw   = rand_wave();
      end
      step(($urandom_range(0, 13) == 0), pend, hw);
      if (last_acc) pend = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
